// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute-stage ALU with single-cycle ops and an iterative shift-add MULTU into HI/LO.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   ready,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   illegal
);
  localparam int W = DATA_WIDTH;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nx;
  logic [W-1:0] hi, lo, mcand, mplier, acc, op_res;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [W:0] sum;
  logic is_mult, op_ill, last;
  always_comb begin
    op_res  = '0;
    op_ill  = 1'b0;
    is_mult = 1'b0;
    case (ALUOp)
      3'b111:
        case (ALUFunction)
          6'b100100: op_res = A & B;
          6'b100101: op_res = A | B;
          6'b100111: op_res = ~(A | B);
          6'b100000: op_res = A + B;
          6'b100010: op_res = A - B;
          6'b000000: op_res = B << shamt;
          6'b000010: op_res = B >> shamt;
          6'b011001: is_mult = 1'b1;
          6'b010000: op_res = hi;
          6'b010010: op_res = lo;
          default:   op_ill = 1'b1;
        endcase
      3'b110, 3'b010: op_res = A + B;
      3'b101: op_res = A | B;
      3'b011: op_res = A & B;
      3'b001: op_res = B << (W / 2);
      default: op_ill = 1'b1;
    endcase
  end
  // One shift-add step: conditional add into the upper half, then shift {acc, mplier} right with carry.
  assign sum   = {1'b0, acc} + {1'b0, {W{mplier[0]}} & mcand};
  assign last  = cnt == SHAMT_WIDTH'(W - 1);
  assign ready = state == IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start && is_mult) state_nx = MUL;
    else if (state == MUL && last) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (is_mult) begin
          mcand  <= A;
          mplier <= B;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          result  <= op_res;
          zero    <= op_res == '0;
          illegal <= op_ill;
          done    <= 1'b1;
        end
      end else if (state == MUL) begin
        acc    <= sum[W:1];
        mplier <= {sum[0], mplier[W-1:1]};
        cnt    <= cnt + 1'b1;
        if (last) begin
          hi      <= sum[W:1];
          lo      <= {sum[0], mplier[W-1:1]};
          result  <= {sum[0], mplier[W-1:1]};
          zero    <= {sum[0], mplier[W-1:1]} == '0;
          illegal <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors into a 32-bit and an 8-bit unit, checked by per-unit scoreboard monitors.
module tb_alu_exec_unit;
  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          due;
    string       nm;
  } exp_t;
  logic clk = 0, reset = 1;
  logic start = 0, start8 = 0;
  logic [2:0] op = 0, op8 = 0, sh8 = 0;
  logic [5:0] fn = 0, fn8 = 0;
  logic [31:0] a = 0, b = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [4:0] sh = 0;
  logic ready, done, zero, illegal, ready8, done8, zero8, illegal8;
  logic [31:0] result;
  logic [7:0] result8;
  int cyc = 0, nvec = 0, nmis = 0;
  exp_t q32[$], q8[$];
  exp_t e32, e8;

  alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(op), .ALUFunction(fn),
    .A(a), .B(b), .shamt(sh), .ready(ready), .done(done), .result(result),
    .zero(zero), .illegal(illegal));
  alu_exec_unit #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ALUOp(op8), .ALUFunction(fn8),
    .A(a8), .B(b8), .shamt(sh8), .ready(ready8), .done(done8), .result(result8),
    .zero(zero8), .illegal(illegal8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset && done) begin
    if (q32.size() == 0) chk("w32 done without start (queued)", 32'(q32.size()), 1);
    else begin
      e32 = q32.pop_front();
      chk({e32.nm, " result"}, result, e32.res);
      chk({e32.nm, " zero"}, {31'b0, zero}, {31'b0, e32.res == 0});
      chk({e32.nm, " illegal"}, {31'b0, illegal}, {31'b0, e32.ill});
      chk({e32.nm, " done cycle"}, cyc, e32.due);
    end
  end

  always @(negedge clk) if (!reset && done8) begin
    if (q8.size() == 0) chk("w8 done without start (queued)", 32'(q8.size()), 1);
    else begin
      e8 = q8.pop_front();
      chk({e8.nm, " result"}, {24'b0, result8}, e8.res);
      chk({e8.nm, " zero"}, {31'b0, zero8}, {31'b0, e8.res == 0});
      chk({e8.nm, " illegal"}, {31'b0, illegal8}, {31'b0, e8.ill});
      chk({e8.nm, " done cycle"}, cyc, e8.due);
    end
  end

  task automatic issue(bit w8, logic [2:0] o, logic [5:0] f, logic [31:0] x, logic [31:0] y,
                       logic [4:0] s, logic [31:0] r, logic il, string nm, bit push);
    int n = 0;
    exp_t e;
    while (!(w8 ? ready8 : ready) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    if (n == 200) chk({nm, " ready wait"}, 0, 1);
    if (w8) begin
      start8 = 1; op8 = o; fn8 = f; a8 = x[7:0]; b8 = y[7:0]; sh8 = s[2:0];
    end else begin
      start = 1; op = o; fn = f; a = x; b = y; sh = s;
    end
    @(posedge clk);
    #1;
    if (push) begin
      e.res = r;
      e.ill = il;
      e.nm  = nm;
      e.due = cyc + ((o == 3'b111 && f == 6'b011001) ? (w8 ? 8 : 32) : 0);
      if (w8) q8.push_back(e);
      else q32.push_back(e);
    end
    start = 0;
    start8 = 0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'b0, ready}, 1);
    chk("rst done", {31'b0, done}, 0);
    chk("rst zero", {31'b0, zero}, 1);
    chk("rst result", result, 0);
    chk("rst illegal", {31'b0, illegal}, 0);
    chk("rst ready8", {31'b0, ready8}, 1);
    reset = 0;
    issue(0, 3'b111, 6'b100000, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0, "add wrap", 1);
    issue(0, 3'b111, 6'b100010, 32'h3, 32'h5, 0, 32'hFFFFFFFE, 0, "sub", 1);
    issue(0, 3'b111, 6'b100111, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0, "nor", 1);
    issue(0, 3'b111, 6'b000010, 32'h0, 32'h80000000, 31, 32'h1, 0, "srl", 1);
    issue(0, 3'b001, 6'b0, 32'h0, 32'h1234, 0, 32'h12340000, 0, "lui", 1);
    issue(0, 3'b111, 6'b100100, 32'hF0F01234, 32'h0FF0FFFF, 0, 32'h00F01234, 0, "and", 1);
    issue(0, 3'b111, 6'b100101, 32'hF0F01234, 32'h0FF0FFFF, 0, 32'hFFF0FFFF, 0, "or", 1);
    issue(0, 3'b111, 6'b000000, 32'h0, 32'h1, 31, 32'h80000000, 0, "sll", 1);
    issue(0, 3'b110, 6'b0, 32'd10, 32'd20, 0, 32'd30, 0, "addi", 1);
    issue(0, 3'b011, 6'b0, 32'hFF00FF00, 32'h0000FFFF, 0, 32'h0000FF00, 0, "andi", 1);
    issue(0, 3'b101, 6'b0, 32'h12340000, 32'h5678, 0, 32'h12345678, 0, "ori", 1);
    issue(0, 3'b010, 6'b0, 32'h1000, 32'hFFFFFFFC, 0, 32'h00000FFC, 0, "lw addr", 1);
    issue(0, 3'b000, 6'b100000, 32'h1, 32'h1, 0, 32'h0, 1, "illegal op000", 1);
    issue(0, 3'b111, 6'b101010, 32'h1, 32'h2, 0, 32'h0, 1, "illegal funct", 1);
    issue(0, 3'b100, 6'b0, 32'h1, 32'h2, 0, 32'h0, 1, "illegal op100", 1);
    issue(0, 3'b111, 6'b100000, 32'h1, 32'h1, 0, 32'h2, 0, "add after illegal", 1);
    issue(0, 3'b111, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1, 0, "multu max", 1);
    issue(0, 3'b111, 6'b010000, 0, 0, 0, 32'hFFFFFFFE, 0, "mfhi max", 1);
    issue(0, 3'b111, 6'b010010, 0, 0, 0, 32'h1, 0, "mflo max", 1);
    issue(0, 3'b111, 6'b011001, 32'h00010001, 32'h00020003, 0, 32'h00050003, 0, "multu spam", 1);
    start = 1; op = 3'b111; fn = 6'b100000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    issue(0, 3'b101, 6'b0, 32'h0, 32'h55, 0, 32'h55, 0, "ori on done", 1);
    issue(0, 3'b111, 6'b010000, 0, 0, 0, 32'h2, 0, "mfhi spam", 1);
    issue(0, 3'b111, 6'b010010, 0, 0, 0, 32'h00050003, 0, "mflo spam", 1);
    issue(0, 3'b111, 6'b011001, 32'd5, 32'd7, 0, 32'h0, 0, "multu abort", 0);
    repeat (9) @(posedge clk);
    #1 reset = 1;
    #1;
    chk("midrst ready", {31'b0, ready}, 1);
    chk("midrst done", {31'b0, done}, 0);
    chk("midrst zero", {31'b0, zero}, 1);
    chk("midrst result", result, 0);
    chk("midrst illegal", {31'b0, illegal}, 0);
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;
    issue(0, 3'b111, 6'b010010, 0, 0, 0, 32'h0, 0, "mflo after rst", 1);
    issue(0, 3'b111, 6'b010000, 0, 0, 0, 32'h0, 0, "mfhi after rst", 1);
    issue(1, 3'b111, 6'b011001, 32'hFF, 32'h02, 0, 32'hFE, 0, "w8 multu", 1);
    issue(1, 3'b111, 6'b010000, 0, 0, 0, 32'h01, 0, "w8 mfhi", 1);
    issue(1, 3'b111, 6'b010010, 0, 0, 0, 32'hFE, 0, "w8 mflo", 1);
    issue(1, 3'b001, 6'b0, 0, 32'h0A, 0, 32'hA0, 0, "w8 lui", 1);
    issue(1, 3'b111, 6'b100000, 32'hFF, 32'h01, 0, 32'h00, 0, "w8 add wrap", 1);
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard drain", 32'(q32.size() + q8.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the multicycle MIPS datapath. It decodes the 3-bit ALUOp from the main control unit and the 6-bit function field, then executes the selected operation on two operands. Logic, add and shift operations complete in one cycle. Unsigned multiply (MULTU) runs as an iterative shift-add sequence into internal HI/LO registers, read back with MFHI/MFLO. A ready/start/done handshake lets the control FSM stall while a multiply is in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; even, ≥8
- SHAMT_WIDTH, 5, shift-amount width; equals clog2(DATA_WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high
- start  in  1  operation request; sampled only when ready=1
- ALUOp  in  3  operation class from control unit
- ALUFunction  in  6  instruction funct field (used when ALUOp=111)
- A  in  DATA_WIDTH  operand A (rs)
- B  in  DATA_WIDTH  operand B (rt or extended immediate)
- shamt  in  SHAMT_WIDTH  shift amount for SLL/SRL
- ready  out  1  unit idle, start will be accepted
- done  out  1  one-cycle pulse, result/zero/illegal valid
- result  out  DATA_WIDTH  registered result, held until next done
- zero  out  1  registered (result == 0)
- illegal  out  1  registered; unsupported {ALUOp, ALUFunction}

## Operation
- Decode (ALUOp_funct -> operation):
  - 111_100100 AND
  - 111_100101 OR
  - 111_100111 NOR
  - 111_100000 ADD
  - 111_100010 SUB
  - 111_000000 SLL B by shamt
  - 111_000010 SRL B by shamt, logical
  - 111_011001 MULTU
  - 111_010000 MFHI
  - 111_010010 MFLO
  - 110 ADDI, A+B
  - 101 ORI, A|B
  - 011 ANDI, A&B
  - 001 LUI, B << DATA_WIDTH/2
  - 010 LW/SW address, A+B
  - Any other encoding: illegal. result=0, illegal=1, done pulses with single-cycle latency.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH with no overflow flag. Shifts fill with zeros.
- MULTU: unsigned A×B, 2·DATA_WIDTH-bit product; HI=upper half, LO=lower half. result on the multiply's done = LO.
- HI/LO change only when a MULTU completes. MFHI/MFLO return the current HI/LO.
- FSM states:
  - IDLE: ready=1.
    - start with a non-MULTU op: compute, register result/zero/illegal, pulse done, stay IDLE.
    - start with MULTU: latch multiplicand=A and multiplier=B, clear accumulator and counter, go MUL.
  - MUL: ready=0. Each cycle, if multiplier LSB=1 add multiplicand into the upper accumulator half, then shift the {acc, multiplier} pair right one bit (carry into MSB). The counter increments each cycle. On the iteration where counter=DATA_WIDTH-1: write HI/LO, result=LO, zero, illegal=0, pulse done, go IDLE.
- start while ready=0 is ignored. The in-flight multiply is not disturbed and its inputs are not used.
- Reset, including mid-multiply: state=IDLE, counter=0, HI=LO=0, result=0, zero=1, illegal=0, done=0, ready=1. The aborted multiply writes nothing.

## Timing
- Accepting edge E0 = rising edge with start=1 and ready=1.
- Single-cycle ops: result/zero/illegal/done valid in the cycle after E0, i.e. latency 1. Back-to-back starts are accepted every cycle, giving one done per cycle.
- MULTU:
  - Iterations occur on edges E1..E_DATA_WIDTH.
  - done rises after edge E_DATA_WIDTH, latency DATA_WIDTH cycles (32 at default).
  - ready is 0 from after E0 until after E_DATA_WIDTH. ready returns to 1 in the same cycle as done, so a new start in that cycle is accepted.
- MFHI immediately following a MULTU done returns the new HI.
- done is never high for two consecutive cycles from one MULTU. It is never high without a preceding accepted start.
- Outputs are driven only from registers; no combinational path from inputs to outputs.

## Test plan
- Reset mid-MULTU (DATA_WIDTH=32): start MULTU, A=5, B=7, then assert reset at cycle 10 -> ready=1, done=0, zero=1, HI=LO=0. A following MFLO returns 0.
- Single-cycle ops: ADD A=0xFFFFFFFF, B=1 -> result=0, zero=1, done one cycle later. SUB A=3, B=5 -> 0xFFFFFFFE. NOR A=0, B=0 -> 0xFFFFFFFF. SRL B=0x80000000, shamt=31 -> 1. LUI B=0x1234 -> 0x12340000.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done exactly 32 cycles after accept with result=0x00000001. Then MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001.
- Handshake: pulse start with ADD throughout a MULTU -> ignored; exactly one done, HI/LO correct. Start ORI in the cycle done rises -> accepted, ORI done on the next cycle.
- Illegal encodings: ALUOp=000, and ALUOp=111 with funct=101010 -> result=0, illegal=1, done after 1 cycle. The next legal op clears illegal.
- DATA_WIDTH=8, SHAMT_WIDTH=3: MULTU 0xFF×0x02 -> done after 8 cycles, HI=0x01, LO=0xFE. LUI B=0x0A -> 0xA0.
